// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// ----------------------------------------------------------------------------
// PS/2 host-to-device transmitter. Sends one command byte to a keyboard or
// mouse over the shared open-drain PS/2 clock/data lines. The block never
// drives a line high: it only asserts pull-down enables.
//
// Sequence: clock is held low for INHIBIT_US microseconds. Data is then pulled
// low (start bit) for one microsecond while clock is still held. Clock is then
// released and the device clocks out d0..d7, odd parity and stop, followed by
// its ack bit. A watchdog aborts the transfer if device clock edges stop
// arriving.
//
// Ports:
//   clk          system clock (single domain)
//   rst          asynchronous, active-high reset
//   tx_data      command byte, latched on accept
//   tx_valid     transfer request, accepted while tx_ready is high
//   tx_ready     high only while idle
//   ps2_clk_i    raw PS/2 clock pin level
//   ps2_data_i   raw PS/2 data pin level
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   busy         high whenever a transfer is in progress
//   tx_done      one-cycle pulse at the end of every transfer
//   tx_status    00 ack, 01 nack, 10 timeout; held until the next tx_done
//
// Optional feature macro: PS2_TX_RESEND_EN
//   Defined:   a nack or timeout restarts the frame from the inhibit phase
//              with the same latched byte, up to MAX_RETRIES times, and
//              tx_done is only pulsed for the final outcome.
//   Undefined: every outcome ends with tx_done; MAX_RETRIES has no effect.
// ----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 65_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_MS  = 15,
  parameter int FILTER_LEN  = 4,
  parameter int MAX_RETRIES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic [1:0] tx_status
);

  // Timing counts, computed in 64 bits because INHIBIT_US * CLK_FREQ_HZ
  // overflows 32 bits at typical clock rates.
  localparam logic [63:0] INH_L   = 64'(INHIBIT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
  localparam logic [63:0] SETUP_L = 64'(CLK_FREQ_HZ) / 64'd1_000_000;
  localparam logic [63:0] TMO_L   = 64'(TIMEOUT_MS) * 64'(CLK_FREQ_HZ) / 64'd1_000;
  localparam logic [31:0] INH     = INH_L[31:0];
  localparam logic [31:0] SETUP   = SETUP_L[31:0];
  localparam logic [31:0] TMO     = TMO_L[31:0];

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    RELEASE
  } state_t;

  state_t                  state;
  logic [1:0]              clk_sync;
  logic [1:0]              data_sync;
  logic [FILTER_LEN-1:0]   clk_hist;
  logic                    clk_filt;
  logic                    fe;
  logic [31:0]             cnt;
  logic [7:0]              byte_q;
  logic                    par_q;
  logic [9:0]              shreg;
  logic [3:0]              bit_cnt;
  logic [1:0]              res;
  logic                    wd_active;
  logic                    wd_expire;
  logic                    rel_done;
  logic                    end_xfer;
  logic [1:0]              end_res;
  logic                    retry;

`ifdef PS2_TX_RESEND_EN
  logic [31:0]             retries;
`else
  logic [31:0]             unused_retry_cfg;
  assign unused_retry_cfg = MAX_RETRIES;
`endif

  // Pin conditioning. Both pins go through a two-stage synchronizer; the
  // clock additionally needs FILTER_LEN agreeing samples before its filtered
  // level changes, which rejects glitches from slow, noisy edges. fe is a
  // single-cycle strobe on every accepted high-to-low change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= '1;
      clk_filt  <= 1'b1;
      fe        <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      data_sync <= {data_sync[0], ps2_data_i};
      clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      fe        <= 1'b0;
      if (&clk_hist) begin
        clk_filt <= 1'b1;
      end else if (~|clk_hist) begin
        clk_filt <= 1'b0;
        fe       <= clk_filt;
      end
    end
  end

  // End-of-transfer decode. The watchdog only runs while waiting on the
  // device; a device edge in the same cycle as expiry wins, since it proves
  // the device is still alive.
  always_comb begin
    wd_active = (state == SEND) || (state == ACK) || (state == RELEASE);
    wd_expire = wd_active && !fe && (cnt == TMO - 32'd1);
    rel_done  = (state == RELEASE) && clk_filt && data_sync[1];
    end_xfer  = wd_expire || rel_done;
    end_res   = wd_expire ? 2'b10 : res;
`ifdef PS2_TX_RESEND_EN
    retry     = end_xfer && (end_res != 2'b00) && (retries < 32'(MAX_RETRIES));
`else
    retry     = 1'b0;
`endif
  end

  // Transfer FSM with registered bus enables and handshake outputs. cnt is
  // shared: it times the inhibit and request phases and then serves as the
  // watchdog from the moment the clock is released. Every exit path clears
  // both enables in the same cycle tx_done is raised, so tx_done never
  // coincides with a line being held low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_status   <= 2'b00;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      cnt         <= '0;
      byte_q      <= '0;
      par_q       <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      res         <= 2'b00;
`ifdef PS2_TX_RESEND_EN
      retries     <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (end_xfer) begin
        cnt         <= '0;
        ps2_data_oe <= 1'b0;
        if (retry) begin
          state      <= INHIBIT;
          ps2_clk_oe <= 1'b1;
`ifdef PS2_TX_RESEND_EN
          retries    <= retries + 32'd1;
`endif
        end else begin
          state      <= IDLE;
          ps2_clk_oe <= 1'b0;
          tx_done    <= 1'b1;
          tx_status  <= end_res;
          tx_ready   <= 1'b1;
          busy       <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid) begin
              byte_q     <= tx_data;
              par_q      <= ~^tx_data;
              state      <= INHIBIT;
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
`ifdef PS2_TX_RESEND_EN
              retries    <= '0;
`endif
            end
          end
          INHIBIT: begin
            if (cnt == INH - 32'd1) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          REQ: begin
            if (cnt == SETUP - 32'd1) begin
              cnt        <= '0;
              ps2_clk_oe <= 1'b0;
              shreg      <= {1'b1, par_q, byte_q};
              bit_cnt    <= '0;
              state      <= SEND;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          SEND: begin
            // The start bit is already on the line; each device falling
            // edge shifts out the next frame bit, stop bit last.
            if (fe) begin
              cnt         <= '0;
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[9:1]};
              bit_cnt     <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) begin
                state <= ACK;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ACK: begin
            if (fe) begin
              cnt   <= '0;
              res   <= data_sync[1] ? 2'b01 : 2'b00;
              state <= RELEASE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          RELEASE: begin
            if (fe) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
